seq_divider: RTL
================

Name: seq_divider

Overview:
- Multi-cycle unsigned integer divider built on repeated shift-and-subtract (restoring division), one quotient bit per clock.
- It is the inverse-direction companion of the repeated-add accumulator datapath in the same arithmetic library.
- Sits beside the accumulator, e.g. to turn an accumulated sum into an average.
- Start/busy/done handshake toward a controlling FSM or testbench.

Parameters:
- DATA_WIDTH, 8, width of dividend, divisor, quotient and remainder; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- clear  input  1  synchronous abort/clear; priority below reset
- start  input  1  request a division; sampled only in IDLE or DONE
- dividend  input  DATA_WIDTH  unsigned numerator; captured when start is accepted
- divisor  input  DATA_WIDTH  unsigned denominator; captured when start is accepted
- quotient  output  DATA_WIDTH  registered result; held until next completion
- remainder  output  DATA_WIDTH  registered result; held until next completion
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when results update
- div_by_zero  output  1  registered flag for the last completed operation; set if divisor was 0

Behaviour:
- Reset (async, active-high): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; iteration counter=0; internal registers=0.
- Priority at each clock edge: reset > clear > start > iteration.
- clear=1: state=IDLE; quotient, remainder and div_by_zero=0; done=0. Valid in any state and aborts RUN.
- FSM states:
  - IDLE: start=1 and divisor!=0 -> capture operands, partial remainder=0, count=0, go to RUN. start=1 and divisor==0 -> go to DONE immediately with quotient=all ones, remainder=dividend, div_by_zero=1.
  - RUN: one iteration per edge, for DATA_WIDTH iterations.
    - Partial remainder is DATA_WIDTH+1 bits: shift in the next dividend MSB, then trial-subtract the divisor.
    - Non-negative trial -> keep the difference, quotient bit=1; otherwise restore, quotient bit=0.
    - At the last iteration (count==DATA_WIDTH-1), register quotient/remainder, div_by_zero=0, go to DONE.
  - DONE: done=1 for exactly this one cycle. Next edge: start=1 is accepted exactly as in IDLE (back-to-back supported); otherwise go to IDLE.
- busy=1 exactly while in RUN. done and busy are never both 1.
- Latency, normal case: start sampled at edge E0; results and done visible after edge E0+DATA_WIDTH (8 clocks for the default width).
- Latency, divide-by-zero: results visible after E0, i.e. 1 clock.
- start while in RUN is ignored. Operand inputs may change freely after capture with no effect on the operation in progress.
- quotient, remainder and div_by_zero change only on entry to DONE, on clear, or on reset. They are never updated mid-RUN.
- Results satisfy dividend = quotient*divisor + remainder with remainder < divisor, for every divisor != 0.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0. After reset releases, no done is ever generated for the aborted operation.

Test Plan:
1. Width 8, start with 100/7 -> busy high for 8 cycles; done pulses once after 8 clocks; quotient=14, remainder=2, div_by_zero=0.
2. Boundaries: 255/1 -> q=255, r=0. 5/9 -> q=0, r=5. 255/255 -> q=1, r=0. 0/3 -> q=0, r=0. Each completes in 8 clocks.
3. Divide-by-zero: 37/0 -> done one clock after start; quotient=255, remainder=37, div_by_zero=1, busy never high. A following 10/3 -> q=3, r=1, div_by_zero=0.
4. Handshake:
   - start 200/13, re-pulse start with 9/9 during RUN -> ignored; result q=15, r=5.
   - Then assert start in the DONE cycle with 50/6 -> accepted; busy next cycle; q=8, r=2 after 8 more clocks.
5. Abort:
   - Assert reset asynchronously at RUN iteration 4 of 100/7 -> outputs 0 immediately, state IDLE, no done pulse.
   - Repeat the same case with clear instead -> same result, taking effect at the next edge.
6. Randomized self-check: 1000 random operand pairs with divisor != 0 -> every done satisfies q*d+r==dividend and r<d.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock,
// with start/busy/done handshake and divide-by-zero reporting.
module seq_divider #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  div_by_zero_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W:0]    rem_q, rem_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  dsr_q, dsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  res_q, res_d;
    logic          dbz_q, dbz_d;
    logic [W:0]    shifted, trial;
    logic          ge;

    // Dividend bits shift out of dvd_q's MSB while quotient bits shift in at its LSB.
    assign shifted = {rem_q[W-1:0], dvd_q[W-1]};
    assign ge      = shifted >= {1'b0, dsr_q};
    assign trial   = ge ? shifted - {1'b0, dsr_q} : shifted;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        if (clear_i) begin
            state_d = IDLE;
            quo_d   = '0;
            res_d   = '0;
            dbz_d   = 1'b0;
        end else if (state_q != RUN && start_i) begin
            if (divisor_i == '0) begin
                state_d = DONE;
                quo_d   = '1;
                res_d   = dividend_i;
                dbz_d   = 1'b1;
            end else begin
                state_d = RUN;
                dvd_d   = dividend_i;
                dsr_d   = divisor_i;
                rem_d   = '0;
                cnt_d   = '0;
            end
        end else if (state_q == RUN) begin
            rem_d = trial;
            dvd_d = {dvd_q[W-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = DONE;
                quo_d   = {dvd_q[W-2:0], ge};
                res_d   = trial[W-1:0];
                dbz_d   = 1'b0;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient_o    = quo_q;
    assign remainder_o   = res_q;
    assign div_by_zero_o = dbz_q;
    assign busy_o        = state_q == RUN;
    assign done_o        = state_q == DONE;
endmodule
